// File: rtl/comp_mult_pkg.sv
// Shared constants for the complex-multiply operand fetch path:
// beat order, fetch FSM encoding and op_data lane placement.
package comp_mult_pkg;

  localparam logic [1:0] BEAT_X1 = 2'd0;
  localparam logic [1:0] BEAT_Y1 = 2'd1;
  localparam logic [1:0] BEAT_X2 = 2'd2;
  localparam logic [1:0] BEAT_Y2 = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // op_data = {x1,x2,y1,y2}; lane n sits at bits [n*W +: W]
  localparam int LANE_X1 = 3;
  localparam int LANE_X2 = 2;
  localparam int LANE_Y1 = 1;
  localparam int LANE_Y2 = 0;

  function automatic int beat_lane(input logic [1:0] beat);
    int lane;
    case (beat)
      BEAT_X1: lane = LANE_X1;
      BEAT_Y1: lane = LANE_Y1;
      BEAT_X2: lane = LANE_X2;
      default: lane = LANE_Y2;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/comp_mult_opf_buf.sv
// Small valid/ready output buffer (1 or 2 entries) for packed operands.
// Ports: clk, rst (async), clr (sync), in_val/in_data push side,
// out_val/out_rdy/out_data pop side, count = entries held.
// The producer reserves space up front, so there is no in_rdy.
module comp_mult_opf_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_val,
  input  logic [W-1:0] in_data,
  output logic         out_val,
  input  logic         out_rdy,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [1:0]   cnt;
  logic         pop;

  assign pop      = out_val & out_rdy;
  assign out_val  = (cnt != 2'd0);
  assign out_data = e0;
  assign count    = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else if (clr) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({in_val, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= in_data;
          else             e1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1 || DEPTH == 1) begin
            e0 <= in_data;
          end else begin
            e0 <= e1;
            e1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/comp_mult_op_fetch.sv
// Operand fetch stage: reads NR_OP complex operand pairs from byte memory
// and offers {x1,x2,y1,y2} on op_val/op_rdy.
// Ports: clk, rst (async), sw_rst (sync), start/op1_ba/op2_ba/nr_op job
// setup, busy/done status, mem_* arbitrated read port, op_* output.
// Macro COMP_MULT_OPF_BUF2_EN: 2-entry output FIFO instead of 1 register.
module comp_mult_op_fetch
  import comp_mult_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int SYS_AW = 16,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw_rst,
  input  logic                start,
  input  logic [SYS_AW-1:0]   op1_ba,
  input  logic [SYS_AW-1:0]   op2_ba,
  input  logic [CNT_W-1:0]    nr_op,
  output logic                busy,
  output logic                done,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [SYS_AW-1:0]   mem_addr,
  input  logic [DWIDTH-1:0]   mem_rd_data,
  output logic                op_val,
  input  logic                op_rdy,
  output logic [4*DWIDTH-1:0] op_data
);

`ifdef COMP_MULT_OPF_BUF2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic [1:0]          state;
  logic [SYS_AW-1:0]   op1_base;
  logic [SYS_AW-1:0]   op2_base;
  logic [SYS_AW-1:0]   off;
  logic [CNT_W-1:0]    ops_left;
  logic [1:0]          beat;
  logic [1:0]          cap_beat;
  logic                cap_vld;
  logic [1:0]          inflight;
  logic [4*DWIDTH-1:0] asm_q;
  logic [4*DWIDTH-1:0] push_data;
  logic                done_q;
  logic [1:0]          buf_cnt;
  logic [2:0]          occ;
  logic                can_begin;
  logic                access;
  logic                op_begin;
  logic                buf_push;
  logic                pop;
  logic                last_pop;

  // an op may start only if a slot stays free for it once it lands
  assign occ       = 3'(buf_cnt) + 3'(inflight);
  assign can_begin = occ < 3'(DEPTH);

  assign mem_req  = (state == ST_FETCH) &&
                    (beat != BEAT_X1 || can_begin);
  assign access   = mem_req & mem_gnt;
  assign mem_ce   = access;
  assign mem_we   = 1'b0;
  assign mem_addr = (beat[1] ? op2_base : op1_base) + off +
                    SYS_AW'(beat[0]);

  assign op_begin = access && (beat == BEAT_X1);
  assign buf_push = cap_vld && (cap_beat == BEAT_Y2);
  assign pop      = op_val & op_rdy;
  assign last_pop = (state == ST_DRAIN) && (inflight == 2'd0) &&
                    (buf_cnt == 2'd1) && pop;

  assign busy = (state != ST_IDLE);
  assign done = done_q;

  // the last beat goes straight from the read bus into the buffer
  always_comb begin
    push_data = asm_q;
    push_data[LANE_Y2*DWIDTH +: DWIDTH] = mem_rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op1_base <= '0;
      op2_base <= '0;
      off      <= '0;
      ops_left <= '0;
      beat     <= BEAT_X1;
      cap_beat <= BEAT_X1;
      cap_vld  <= 1'b0;
      inflight <= 2'd0;
      asm_q    <= '0;
      done_q   <= 1'b0;
    end else if (sw_rst) begin
      state    <= ST_IDLE;
      op1_base <= '0;
      op2_base <= '0;
      off      <= '0;
      ops_left <= '0;
      beat     <= BEAT_X1;
      cap_beat <= BEAT_X1;
      cap_vld  <= 1'b0;
      inflight <= 2'd0;
      asm_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op1_base <= op1_ba;
            op2_base <= op2_ba;
            ops_left <= nr_op;
            off      <= '0;
            beat     <= BEAT_X1;
            if (nr_op == '0) done_q <= 1'b1;
            else             state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (access) begin
            beat <= beat + 2'd1;
            if (beat == BEAT_Y2) begin
              off      <= off + SYS_AW'(2);
              ops_left <= ops_left - CNT_W'(1);
              if (ops_left == CNT_W'(1)) state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (last_pop) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      inflight <= inflight + 2'(op_begin) - 2'(buf_push);
      cap_vld  <= access;
      cap_beat <= beat;
      if (cap_vld)
        asm_q[beat_lane(cap_beat)*DWIDTH +: DWIDTH] <= mem_rd_data;
    end
  end

  comp_mult_opf_buf #(
    .W     (4*DWIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clr      (sw_rst),
    .in_val   (buf_push),
    .in_data  (push_data),
    .out_val  (op_val),
    .out_rdy  (op_rdy),
    .out_data (op_data),
    .count    (buf_cnt)
  );

endmodule

// File: tb/tb_comp_mult_op_fetch.sv
// Directed bench for comp_mult_op_fetch with a byte memory model
// and a negedge monitor recording accesses and handshakes.
module tb_comp_mult_op_fetch;

`ifdef COMP_MULT_OPF_BUF2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw_rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op1_ba = '0;
  logic [15:0] op2_ba = '0;
  logic [15:0] nr_op = '0;
  logic        busy, done, mem_req, mem_ce, mem_we;
  logic        mem_gnt = 1'b1;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data = '0;
  logic        op_val;
  logic        op_rdy = 1'b1;
  logic [31:0] op_data;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] addr_q [$];
  logic [31:0] data_q [$];
  int cyc = 0, acc_cnt = 0, hs_cnt = 0, done_cnt = 0;
  int start_cyc = 0, first_val = -1, done_cyc = 0, hs_cyc = 0;
  int stall_err = 0, ovf_err = 0, we_err = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;

  comp_mult_op_fetch dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .start(start),
    .op1_ba(op1_ba), .op2_ba(op2_ba), .nr_op(nr_op),
    .busy(busy), .done(done), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .op_val(op_val), .op_rdy(op_rdy), .op_data(op_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_ce) mem_rd_data <= mem[mem_addr];

  always @(negedge clk) begin
    cyc++;
    if (mem_ce) begin
      addr_q.push_back(mem_addr);
      acc_cnt++;
    end
    if (mem_we) we_err++;
    if (stall_prev && (!op_val || op_data !== stall_data)) stall_err++;
    stall_prev = op_val && !op_rdy;
    stall_data = op_data;
    if (op_val && op_rdy) begin
      data_q.push_back(op_data);
      hs_cnt++;
      hs_cyc = cyc;
    end
    if (((acc_cnt + 3) / 4) - hs_cnt > DEPTH) ovf_err++;
    if (op_val && first_val < 0) first_val = cyc;
    if (start) start_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [31:0] exp_op(input logic [15:0] b1,
                                         input logic [15:0] b2,
                                         input int k);
    logic [15:0] a1, a2;
    a1 = b1 + 16'(2 * k);
    a2 = b2 + 16'(2 * k);
    return {mem[a1], mem[a2], mem[16'(a1 + 16'd1)], mem[16'(a2 + 16'd1)]};
  endfunction

  task automatic clear_mon();
    addr_q.delete();
    data_q.delete();
    acc_cnt = 0; hs_cnt = 0; done_cnt = 0;
    first_val = -1; stall_err = 0; ovf_err = 0; we_err = 0;
  endtask

  task automatic run_job(input logic [15:0] b1, input logic [15:0] b2,
                         input logic [15:0] n, input bit gtog,
                         input int rdy_dly, input int dup_at,
                         input int max_cyc);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    clear_mon();
    op1_ba = b1; op2_ba = b2; nr_op = n;
    start = 1'b1;
    mem_gnt = gtog ? 1'b0 : 1'b1;
    op_rdy = (rdy_dly <= 0);
    for (int i = 1; i < max_cyc; i++) begin
      @(posedge clk); #1;
      start = (i == dup_at);
      if (i == dup_at) begin
        op1_ba = b1 + 16'h55; op2_ba = b2 + 16'h33;
      end
      mem_gnt = gtog ? logic'(i[0]) : 1'b1;
      op_rdy = (i >= rdy_dly);
      if (done_cnt != 0) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0; mem_gnt = 1'b1; op_rdy = 1'b1;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL timeout: no done within %0d cycles (n=%0d)", max_cyc, n);
    end
  endtask

  task automatic check_job(input string name, input logic [15:0] b1,
                           input logic [15:0] b2, input int n);
    tests++;
    if (hs_cnt !== n) begin
      fails++;
      $display("FAIL %s op_count: got %0d want %0d", name, hs_cnt, n);
    end
    tests++;
    if (acc_cnt !== 4 * n) begin
      fails++;
      $display("FAIL %s reads: got %0d want %0d", name, acc_cnt, 4 * n);
    end
    for (int k = 0; k < n && k < data_q.size(); k++) begin
      tests++;
      if (data_q[k] !== exp_op(b1, b2, k)) begin
        fails++;
        $display("FAIL %s op%0d data: got %h want %h", name, k,
                 data_q[k], exp_op(b1, b2, k));
      end
    end
    for (int k = 0; k < n && 4 * k + 3 < addr_q.size(); k++) begin
      tests++;
      if ({addr_q[4*k], addr_q[4*k+1], addr_q[4*k+2], addr_q[4*k+3]} !==
          {16'(b1 + 16'(2*k)), 16'(b1 + 16'(2*k+1)),
           16'(b2 + 16'(2*k)), 16'(b2 + 16'(2*k+1))}) begin
        fails++;
        $display("FAIL %s op%0d addr: got %h %h %h %h", name, k,
                 addr_q[4*k], addr_q[4*k+1], addr_q[4*k+2], addr_q[4*k+3]);
      end
    end
    tests++;
    if (done_cnt !== 1 || (n > 0 && done_cyc !== hs_cyc + 1)) begin
      fails++;
      $display("FAIL %s done: count %0d at %0d, want 1 at %0d", name,
               done_cnt, done_cyc, hs_cyc + 1);
    end
    tests++;
    if (we_err !== 0) begin
      fails++;
      $display("FAIL %s mem_we: got %0d writes want 0", name, we_err);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, mem_req, op_val, mem_ce} !== 5'b0 || op_data !== 32'h0) begin
      fails++;
      $display("FAIL reset: busy/done/req/val/ce=%b%b%b%b%b data=%h want 0",
               busy, done, mem_req, op_val, mem_ce, op_data);
    end
  endtask

  task automatic test_single();
    run_job(16'd100, 16'd200, 16'd1, 1'b0, 0, -1, 100);
    tests++;
    if (data_q.size() < 1 || data_q[0] !== 32'h03050406) begin
      fails++;
      $display("FAIL single data: got %h want 03050406",
               data_q.size() > 0 ? data_q[0] : 32'hx);
    end
    tests++;
    if (first_val - start_cyc !== 6) begin
      fails++;
      $display("FAIL single latency: got %0d want 6", first_val - start_cyc);
    end
    check_job("single", 16'd100, 16'd200, 1);
  endtask

  task automatic test_stream();
    run_job(16'd1000, 16'd2000, 16'd10, 1'b0, 0, -1, 1000);
    check_job("stream", 16'd1000, 16'd2000, 10);
  endtask

  task automatic test_zero();
    run_job(16'd50, 16'd60, 16'd0, 1'b0, 0, -1, 20);
    tests++;
    if (done_cyc - start_cyc !== 1 || done_cnt !== 1) begin
      fails++;
      $display("FAIL zero done: %0d pulses, delay %0d want 1 pulse delay 1",
               done_cnt, done_cyc - start_cyc);
    end
    tests++;
    if (acc_cnt !== 0) begin
      fails++;
      $display("FAIL zero reads: got %0d want 0", acc_cnt);
    end
  endtask

  task automatic test_stall();
    run_job(16'd3000, 16'd4000, 16'd6, 1'b1, 20, -1, 2000);
    tests++;
    if (stall_err !== 0) begin
      fails++;
      $display("FAIL stall stable: got %0d changes want 0", stall_err);
    end
    tests++;
    if (ovf_err !== 0) begin
      fails++;
      $display("FAIL stall depth: got %0d overfills want 0", ovf_err);
    end
    check_job("stall", 16'd3000, 16'd4000, 6);
  endtask

  task automatic test_wrap();
    run_job(16'hFFFF, 16'h0010, 16'd1, 1'b0, 0, -1, 100);
    tests++;
    if (addr_q.size() < 2 || addr_q[0] !== 16'hFFFF || addr_q[1] !== 16'h0000) begin
      fails++;
      $display("FAIL wrap addr: got %h %h want ffff 0000",
               addr_q.size() > 0 ? addr_q[0] : 16'hx,
               addr_q.size() > 1 ? addr_q[1] : 16'hx);
    end
    check_job("wrap", 16'hFFFF, 16'h0010, 1);
  endtask

  task automatic test_back_to_back();
    run_job(16'd500, 16'd600, 16'd3, 1'b0, 0, 5, 500);
    check_job("busy_start", 16'd500, 16'd600, 3);
  endtask

  task automatic test_sw_rst();
    bit hit;
    hit = 1'b0;
    @(posedge clk); #1;
    clear_mon();
    op1_ba = 16'd300; op2_ba = 16'd400; nr_op = 16'd10;
    start = 1'b1; mem_gnt = 1'b1; op_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (acc_cnt >= 9) begin
        hit = 1'b1;
        break;
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL swrst timeout: only %0d reads", acc_cnt);
    end
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    tests++;
    if ({busy, done, mem_req, op_val} !== 4'b0 || op_data !== 32'h0) begin
      fails++;
      $display("FAIL swrst outputs: busy/done/req/val=%b%b%b%b data=%h want 0",
               busy, done, mem_req, op_val, op_data);
    end
    repeat (10) @(negedge clk);
    tests++;
    if (done_cnt !== 0) begin
      fails++;
      $display("FAIL swrst done: got %0d pulses want 0", done_cnt);
    end
    run_job(16'd300, 16'd400, 16'd3, 1'b0, 0, -1, 300);
    check_job("restart", 16'd300, 16'd400, 3);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 13 + 7);
    mem[100] = 8'd3; mem[101] = 8'd4;
    mem[200] = 8'd5; mem[201] = 8'd6;
    test_reset();
    test_single();
    test_stream();
    test_zero();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_sw_rst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
